// File: rtl/hub75_panel_rx.sv
// hub75_panel_rx -- panel-side receiver for a HUB75 link.
//
// Oversamples the HUB75 pins on clk and rebuilds every latched row pair
// into an internal frame store. The store can be read back one pixel at a
// time, and the block reports frame and error status.
//
// Ports
//   clk                  system clock, rising edge
//   rst                  asynchronous active-low reset (internally synchronised release)
//   sclk, lat, oe        HUB75 shift clock, latch, output enable (oe active-low), async
//   A, B, C, D           row-pair address, A = LSB, async
//   R0,G0,B0 / R1,G1,B1  upper / lower half pixel data, async
//   rd_row, rd_col       readback pixel coordinate
//   rd_rgb               {R,G,B} at (rd_row, rd_col), one cycle after the coordinate
//   frame_done           one-cycle pulse when row pair 15 latches right after row pair 14
//   frame_cnt            completed frames, wraps 255 -> 0
//   shift_err            sticky, a latch arrived with a shift count other than COLS
//   oe_err               sticky, latch or address change while LEDs were lit
//
// Optional feature: define HUB75_RX_OE_CHECK_EN to build the oe_err checker.
// Without the macro, oe_err is tied low and the checker logic is absent.
module hub75_panel_rx #(
    parameter int COLS = 32,
    parameter int ROWS = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sclk,
    input  logic                      lat,
    input  logic                      oe,
    input  logic                      A,
    input  logic                      B,
    input  logic                      C,
    input  logic                      D,
    input  logic                      R0,
    input  logic                      G0,
    input  logic                      B0,
    input  logic                      R1,
    input  logic                      G1,
    input  logic                      B1,
    input  logic [$clog2(ROWS)-1:0]   rd_row,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    output logic [2:0]                rd_rgb,
    output logic                      frame_done,
    output logic [7:0]                frame_cnt,
    output logic                      shift_err,
    output logic                      oe_err
);

    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int BW  = CW + 1;
    localparam int SW  = COLS * 3;
    localparam int SIW = $clog2(SW);
    localparam logic [BW-1:0] BIT_MAX  = BW'(2 * COLS - 1);
    localparam logic [BW-1:0] BIT_FULL = BW'(COLS);
    localparam logic [RW-1:0] HALF     = RW'(ROWS / 2);

    // Reset: asserts immediately, releases two clk edges later.
    logic rst_meta_q, rst_n_q;

    // Reset release synchroniser
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    // Pin bundle: {sclk, lat, D, C, B, A, R0, G0, B0, R1, G1, B1}
    logic [11:0] pins_s;
    logic [11:0] sync1_q, sync2_q;
    logic        sclk_prev_q, lat_prev_q;
    logic        sclk_rise_s, lat_rise_s;
    logic [3:0]  addr_s2_s;

    assign pins_s      = {sclk, lat, D, C, B, A, R0, G0, B0, R1, G1, B1};
    assign addr_s2_s   = sync2_q[9:6];
    assign sclk_rise_s = sync2_q[11] & ~sclk_prev_q;
    assign lat_rise_s  = sync2_q[10] & ~lat_prev_q;

    // Event stage: one registered cycle between edge detection and action
    logic        sclk_det_q, lat_det_q;
    logic [2:0]  up_bit_q, lo_bit_q;
    logic [3:0]  lat_addr_q;

    // Two-flop synchronisers, edge detection and event capture
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            sync1_q     <= 12'd0;
            sync2_q     <= 12'd0;
            sclk_prev_q <= 1'b0;
            lat_prev_q  <= 1'b0;
            sclk_det_q  <= 1'b0;
            lat_det_q   <= 1'b0;
            up_bit_q    <= 3'd0;
            lo_bit_q    <= 3'd0;
            lat_addr_q  <= 4'd0;
        end else begin
            sync1_q     <= pins_s;
            sync2_q     <= sync1_q;
            sclk_prev_q <= sync2_q[11];
            lat_prev_q  <= sync2_q[10];
            sclk_det_q  <= sclk_rise_s;
            lat_det_q   <= lat_rise_s;
            up_bit_q    <= sync2_q[5:3];
            lo_bit_q    <= sync2_q[2:0];
            lat_addr_q  <= addr_s2_s;
        end
    end

    logic [SW-1:0] up_sh_q, lo_sh_q, up_sh_d, lo_sh_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;

    // Post-shift view of the shift registers; a latch in the same cycle
    // stores these values so a coincident shift lands in the row.
    always_comb begin
        up_sh_d   = up_sh_q;
        lo_sh_d   = lo_sh_q;
        bit_cnt_d = bit_cnt_q;
        if (sclk_det_q) begin
            up_sh_d = {up_sh_q[SW-4:0], up_bit_q};
            lo_sh_d = {lo_sh_q[SW-4:0], lo_bit_q};
            if (bit_cnt_q != BIT_MAX) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    logic [RW-1:0] up_row_s, lo_row_s;
    assign up_row_s = RW'(lat_addr_q);
    assign lo_row_s = up_row_s + HALF;

    logic [3:0] last_addr_q;
    logic       frame_done_q;
    logic [7:0] frame_cnt_q;
    logic       shift_err_q;

    // Shift registers, bit counter, frame tracking and shift error
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            up_sh_q      <= {SW{1'b0}};
            lo_sh_q      <= {SW{1'b0}};
            bit_cnt_q    <= {BW{1'b0}};
            last_addr_q  <= 4'd15;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            shift_err_q  <= 1'b0;
        end else begin
            up_sh_q      <= up_sh_d;
            lo_sh_q      <= lo_sh_d;
            frame_done_q <= 1'b0;
            if (lat_det_q) begin
                bit_cnt_q   <= {BW{1'b0}};
                last_addr_q <= lat_addr_q;
                if (bit_cnt_d != BIT_FULL) begin
                    shift_err_q <= 1'b1;
                end
                // Re-latching the same address refreshes the row only
                if (lat_addr_q == 4'd15 && last_addr_q == 4'd14) begin
                    frame_done_q <= 1'b1;
                    frame_cnt_q  <= frame_cnt_q + 8'd1;
                end
            end else begin
                bit_cnt_q <= bit_cnt_d;
            end
        end
    end

    logic [SW-1:0] mem_q [ROWS];

    // Frame store: both halves of a row pair written on the latch cycle
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            for (int i = 0; i < ROWS; i++) begin
                mem_q[i] <= {SW{1'b0}};
            end
        end else begin
            if (lat_det_q) begin
                mem_q[up_row_s] <= up_sh_d;
                mem_q[lo_row_s] <= lo_sh_d;
            end
        end
    end

    logic [SW-1:0]  rd_line_s;
    logic [SIW-1:0] rd_base_s;
    logic [2:0]     rd_rgb_q;

    assign rd_line_s = mem_q[rd_row];
    assign rd_base_s = SIW'({rd_col, 1'b0}) + SIW'(rd_col);

    // Registered readback; a same-cycle write is not visible yet
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            rd_rgb_q <= 3'd0;
        end else begin
            rd_rgb_q <= rd_line_s[rd_base_s +: 3];
        end
    end

    assign rd_rgb     = rd_rgb_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign shift_err  = shift_err_q;

`ifdef HUB75_RX_OE_CHECK_EN
    logic       oe_meta_q, oe_s2_q, oe_err_q;
    logic [3:0] addr_prev_q;

    // oe synchroniser and ghosting checks (latch or address move while lit)
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            oe_meta_q   <= 1'b1;
            oe_s2_q     <= 1'b1;
            addr_prev_q <= 4'd0;
            oe_err_q    <= 1'b0;
        end else begin
            oe_meta_q   <= oe;
            oe_s2_q     <= oe_meta_q;
            addr_prev_q <= addr_s2_s;
            if (!oe_s2_q && (lat_rise_s || addr_s2_s != addr_prev_q)) begin
                oe_err_q <= 1'b1;
            end
        end
    end

    assign oe_err = oe_err_q;
`else
    logic unused_oe_s;
    assign unused_oe_s = oe;
    assign oe_err      = 1'b0;
`endif

endmodule
